// File: rtl/result_source_pkg.sv
// Shared encodings and constants for the result/guess stream source.
// The LFSR constants are only used when RESULT_SOURCE_LFSR_RUN_EN is defined.
package result_source_pkg;

    localparam int DEF_RUN_W = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hit and miss scores.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             at_max
);

    assign at_max = &value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (inc && !at_max) begin
            value <= value + 1'b1;
        end
    end

endmodule

// File: rtl/result_source.sv
// Alternating low/high result stream with programmable run lengths, scoring a predictor's guess.
// Define RESULT_SOURCE_LFSR_RUN_EN to take run lengths from an internal LFSR instead of the ports.
module result_source
    import result_source_pkg::*;
#(
    parameter int RUN_W = DEF_RUN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [RUN_W-1:0] low_len,
    input  logic [RUN_W-1:0] high_len,
    input  logic             guess,
    output logic             result,
    output logic             run_start,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] ALMOST_MAX = {{(CNT_W-1){1'b1}}, 1'b0};

    state_t           state, state_next;
    logic [RUN_W-1:0] run_cnt, run_cnt_next;
    logic             result_next, run_start_next;
    logic             start_run;
    logic [RUN_W-1:0] low_src, high_src;
    logic             scoring, hit_inc, miss_inc, hit_at_max, miss_at_max;

    function automatic logic [RUN_W-1:0] len_m1(input logic [RUN_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

`ifdef RESULT_SOURCE_LFSR_RUN_EN
    logic [7:0] lfsr;
    logic       unused_len_ports;

    assign unused_len_ports = ^{low_len, high_len};
    assign low_src          = lfsr[RUN_W-1:0];
    assign high_src         = lfsr[RUN_W-1:0];

    // Advances once per run so each new run draws a fresh length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (start_run) begin
            lfsr <= lfsr_step(lfsr);
        end
    end
`else
    assign low_src  = low_len;
    assign high_src = high_len;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            run_cnt   <= '0;
            result    <= 1'b0;
            run_start <= 1'b0;
            sat       <= 1'b0;
        end else begin
            state     <= state_next;
            run_cnt   <= run_cnt_next;
            result    <= result_next;
            run_start <= run_start_next;
            if ((hit_inc && hit_cnt == ALMOST_MAX) || (miss_inc && miss_cnt == ALMOST_MAX)) begin
                sat <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        run_cnt_next = run_cnt;
        start_run    = 1'b0;
        if (en) begin
            case (state)
                ST_IDLE: begin
                    state_next   = ST_LOW;
                    run_cnt_next = len_m1(low_src);
                    start_run    = 1'b1;
                end
                ST_LOW, ST_HIGH: begin
                    if (run_cnt != '0) begin
                        run_cnt_next = run_cnt - 1'b1;
                    end else begin
                        state_next   = (state == ST_LOW) ? ST_HIGH : ST_LOW;
                        run_cnt_next = (state == ST_LOW) ? len_m1(high_src) : len_m1(low_src);
                        start_run    = 1'b1;
                    end
                end
                default: begin
                    state_next   = ST_IDLE;
                    run_cnt_next = '0;
                end
            endcase
        end
    end

    // The stream bit is simply the phase of the upcoming state
    always_comb begin
        result_next    = (state_next == ST_HIGH);
        run_start_next = start_run;
    end

    assign scoring  = en && (state == ST_LOW || state == ST_HIGH);
    assign hit_inc  = scoring && (guess == result) && !hit_at_max;
    assign miss_inc = scoring && (guess != result) && !miss_at_max;

    sat_counter #(.CNT_W(CNT_W)) u_hit_counter (
        .clk    (clk),
        .rst    (rst),
        .inc    (hit_inc),
        .value  (hit_cnt),
        .at_max (hit_at_max)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_counter (
        .clk    (clk),
        .rst    (rst),
        .inc    (miss_inc),
        .value  (miss_cnt),
        .at_max (miss_at_max)
    );

endmodule
